// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (uart_rx, uart_tx, uart_interface).
//   uart_state_t    : receiver FSM state encoding (3 bits)
//   OVERSAMPLE      : baud ticks per bit period
//   START_MID       : tick count at which the start bit is re-checked (mid-bit)
//   NB_DATA_DEFAULT : data bits per character shared by all UART blocks
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE      = 16;
  localparam int START_MID       = 7;
  localparam int NB_DATA_DEFAULT = 8;

endpackage : uart_pkg

// File: rtl/baud_rate_gen.sv
// -----------------------------------------------------------------------------
// baud_rate_gen
// Free-running divider producing a one-cycle tick at 16x the baud rate.
//   DIV = CLK_FREQ / (BAUD_RATE * 16), truncated; DIV < 2 is rejected.
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-high reset, counter returns to 0
//   o_tick  : high for one cycle when the counter equals DIV-1
// -----------------------------------------------------------------------------
module baud_rate_gen #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 19_200
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("baud_rate_gen: DIV must be at least 2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tick = (cnt_q == CNT_LAST);

endmodule : baud_rate_gen

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 (by default) UART receiver with 16x oversampling, LSB first.
// Ports:
//   i_clk         : system clock, the only clock
//   i_reset       : synchronous active-high reset
//   i_rx          : asynchronous serial line, idles high
//   o_rx_data     : last correctly framed byte, held until the next good frame
//   o_rx_done     : one-cycle strobe, o_rx_data valid in the same cycle
//   o_frame_error : one-cycle strobe when the stop bit is sampled low
//   o_dbg_state   : current FSM state (uart_state_t encoding)
// Handshake: o_rx_done is a valid-only strobe with no ready; the consumer must
// take o_rx_data in the strobe cycle (it stays stable afterwards anyway).
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 19_200,
  parameter int NB_DATA   = NB_DATA_DEFAULT,
  parameter int SB_TICK   = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_error,
  output logic [2:0]         o_dbg_state
);

  localparam int N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  if (SB_TICK < 1 || SB_TICK > 16) begin : g_sb_check
    $error("uart_rx: SB_TICK must be in 1..16");
  end

  localparam logic [3:0]     S_START_MID = 4'(START_MID);
  localparam logic [3:0]     S_BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]     S_STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(NB_DATA - 1);

  // ---------------------------------------------------------------------------
  // Baud tick
  // ---------------------------------------------------------------------------
  logic tick;

  baud_rate_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_rate_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle (high) line level so reset
  // release never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  uart_state_t        state_q, state_d;
  logic [3:0]         s_q, s_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic. Outside IDLE/BREAK every counter update is gated by tick;
  // the IDLE->START transition ignores a coincident tick, so the start bit is
  // checked after a full START_MID+1 ticks.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (s_q == S_START_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high before mid-bit: noise, not a start bit.
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[NB_DATA-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s_q == S_STOP_LAST) begin
            if (rx_s) begin
              data_d  = b_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      ST_BREAK: begin
        // Hold here while the line stays low so a break is reported once.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_rx_data     = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;
  assign o_dbg_state   = state_q;

endmodule : uart_rx
